pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_pkg.sv | 6 +
 rtl/pc_next_mux.sv | 14 +
 rtl/pc_fetch_unit.sv | 79 +++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared FSM state type and default widths for the fetch unit.
package pc_fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, STALL} state_e;
  localparam int ADDR_W_DEF = 16;
  localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC select with priority reset > jump > increment > hold.
module pc_next_mux import pc_fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              rst_i,
  input  logic              jmp_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] jmp_loc_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_d_o
);
  always_comb pc_d_o = rst_i ? RESET_VECTOR : jmp_i ? jmp_loc_i : adv_i ? pc_i + ADDR_W'(1) : pc_i;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, fetch FSM and decode handoff; define PC_WRAP_TRAP_EN
// to trap on increment past all-ones instead of wrapping to zero.
module pc_fetch_unit import pc_fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              pc_mux_sel,
  input  logic              stall,
  input  logic              pm_ready,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_req,
  output logic [ADDR_W-1:0] current_address,
  output logic              if_valid,
  output logic              flush,
  output logic              wrap_err
);
  state_e state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, cur_q;
  logic valid_q, flush_q, halt, accept, wrap_hit, fetching;
  assign fetching = state_q == FETCH || state_q == WAIT;
  assign accept = !pc_mux_sel && !stall && pm_ready && !halt && fetching;
  assign pm_req = !reset && !halt && fetching;
  assign pm_addr = pc_q;
  assign current_address = cur_q;
  assign if_valid = valid_q;
  assign flush = flush_q;
`ifdef PC_WRAP_TRAP_EN
  logic wrap_q, halt_q;
  assign wrap_hit = accept && (&pc_q);
  assign halt = halt_q;
  assign wrap_err = wrap_q;
  // wrap_err is sticky until reset; only the request block is lifted by a redirect
  always_ff @(posedge clk)
    if (reset) begin
      wrap_q <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      wrap_q <= wrap_q | wrap_hit;
      halt_q <= pc_mux_sel ? 1'b0 : halt_q | wrap_hit;
    end
`else
  assign wrap_hit = 1'b0;
  assign halt = 1'b0;
  assign wrap_err = 1'b0;
`endif
  pc_next_mux #(.ADDR_W(ADDR_W), .RESET_VECTOR(RESET_VECTOR)) u_next (
    .rst_i(reset), .jmp_i(pc_mux_sel), .adv_i(accept && !wrap_hit),
    .jmp_loc_i(jmp_loc), .pc_i(pc_q), .pc_d_o(pc_d)
  );
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (reset) begin
      state_q <= BOOT;
      cur_q <= RESET_VECTOR;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else if (pc_mux_sel) begin
      state_q <= FETCH;
      valid_q <= 1'b0;
      flush_q <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      if (state_q == BOOT) state_q <= FETCH;
      else if (stall) state_q <= STALL;
      else if (state_q == STALL) state_q <= FETCH;
      else if (accept) begin
        state_q <= FETCH;
        cur_q <= pc_q;
        valid_q <= 1'b1;
      end else begin
        state_q <= WAIT;
        valid_q <= 1'b0;
      end
    end
  end
endmodule
